hr_prbs16_gen: RTL

// - Parallel PRBS/pattern source that drives the 16-bit din bus of the half-rate 16:4 mux.
// - Runs on the mux's divided clock (clk_prbs) and produces 16 new serial bits per cycle.
// - Selectable PRBS7/9/15/31, fixed and user patterns, seed load, polarity invert and

---
 rtl/hr_prbs16_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hr_prbs16_gen.sv
// Parallel PRBS7/9/15/31, clock and user pattern word source for the half-rate 16:4 mux.
// Latency: one clk_prbs edge from an enabled cycle to the registered dout word.
// Backpressure: en=0 holds generator state and output; no word is dropped or skipped.
module hr_prbs16_gen #(
    parameter logic [30:0] DEF_SEED = 31'h7FFF_FFFF,
    parameter logic [2:0]  DEF_MODE = 3'd0
) (
    input  logic        clk_prbs,
    input  logic        rst_n,
    input  logic        en,
    input  logic [2:0]  mode,
    input  logic        seed_load,
    input  logic [30:0] seed,
    input  logic [15:0] pattern,
    input  logic        inv,
    input  logic        err_inj,
    output logic [15:0] dout,
    output logic        dout_vld,
    output logic [7:0]  reseed_cnt
);

    typedef enum logic [2:0] {
        MODE_PRBS7  = 3'd0,
        MODE_PRBS9  = 3'd1,
        MODE_PRBS15 = 3'd2,
        MODE_PRBS31 = 3'd3,
        MODE_CLK    = 3'd4,
        MODE_USER   = 3'd5,
        MODE_ZERO6  = 3'd6,
        MODE_ZERO7  = 3'd7
    } mode_e;

    // Live LFSR bits per mode; non-PRBS modes keep the whole register as loaded.
    function automatic logic [30:0] live_mask(input logic [2:0] m);
        logic [30:0] msk;
        case (m)
            3'd0:    msk = 31'h0000_007F;
            3'd1:    msk = 31'h0000_01FF;
            3'd2:    msk = 31'h0000_7FFF;
            default: msk = 31'h7FFF_FFFF;
        endcase
        return msk;
    endfunction

    // Sixteen Fibonacci steps unrolled; step k feeds word bit k. Returns {next_state, word}.
    function automatic logic [46:0] lfsr_adv16(input logic [30:0] s_in, input logic [2:0] m);
        logic [30:0] s;
        logic [15:0] w;
        logic        b;
        s = s_in;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            case (m)
                3'd0:    b = s[6]  ^ s[5];
                3'd1:    b = s[8]  ^ s[4];
                3'd2:    b = s[14] ^ s[13];
                3'd3:    b = s[30] ^ s[27];
                default: b = 1'b0;
            endcase
            w[k] = b;
            s    = {s[29:0], b} & live_mask(m);
        end
        return {s, w};
    endfunction

    localparam logic [30:0] RST_STATE = DEF_SEED & live_mask(DEF_MODE);

    logic [30:0] state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [15:0] dout_q, dout_d;
    logic        dout_vld_q, dout_vld_d;
    logic [7:0]  reseed_cnt_q, reseed_cnt_d;
    logic        err_pend_q, err_pend_d;

    logic [30:0] adv_state;
    logic [15:0] adv_word;
    logic [15:0] gen_word;
    logic        is_prbs;
    logic        mode_chg;
    logic        state_zero;
    logic        err_now;

    assign {adv_state, adv_word} = lfsr_adv16(state_q, mode_q);

    assign is_prbs    = ~mode_q[2];
    assign mode_chg   = (mode != mode_q);
    assign state_zero = ((state_q & live_mask(mode_q)) == 31'd0);
    assign err_now    = err_pend_q | err_inj;

    always_comb begin
        gen_word = 16'h0000;
        case (mode_q)
            MODE_PRBS7, MODE_PRBS9, MODE_PRBS15, MODE_PRBS31: gen_word = adv_word;
            MODE_CLK:                                         gen_word = 16'hAAAA;
            MODE_USER:                                        gen_word = pattern;
            default:                                          gen_word = 16'h0000;
        endcase
    end

    // Priority: mode change, seed load, all-zero recovery, then normal word generation.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        dout_d       = dout_q;
        dout_vld_d   = dout_vld_q;
        reseed_cnt_d = reseed_cnt_q;
        err_pend_d   = err_now;

        if (mode_chg) begin
            mode_d     = mode_e'(mode);
            state_d    = seed & live_mask(mode);
            dout_vld_d = 1'b0;
        end else if (seed_load) begin
            state_d    = seed & live_mask(mode_q);
            dout_vld_d = 1'b0;
        end else if (is_prbs && state_zero) begin
            state_d    = live_mask(mode_q);
            dout_vld_d = 1'b0;
            if (reseed_cnt_q != 8'hFF) begin
                reseed_cnt_d = reseed_cnt_q + 8'd1;
            end
        end else if (en) begin
            if (is_prbs) begin
                state_d = adv_state;
            end
            dout_d     = gen_word ^ {16{inv}} ^ {15'd0, err_now};
            dout_vld_d = 1'b1;
            err_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_prbs or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_STATE;
            mode_q       <= mode_e'(DEF_MODE);
            dout_q       <= 16'h0000;
            dout_vld_q   <= 1'b0;
            reseed_cnt_q <= 8'h00;
            err_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
            reseed_cnt_q <= reseed_cnt_d;
            err_pend_q   <= err_pend_d;
        end
    end

    assign dout       = dout_q;
    assign dout_vld   = dout_vld_q;
    assign reseed_cnt = reseed_cnt_q;

endmodule
